// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : dm_access_unit
//  Purpose  : Data-memory access unit. Turns one CPU load/store into a single
//             req/ack transaction on a word-wide memory port with variable
//             latency. It generates byte enables and lane-replicated store
//             data, and extracts and extends load data. The CPU is stalled
//             until the access completes.
//  Ports    : clk, rst                    - clock, synchronous active-high reset
//             MemRead, MemWrite, LAddr    - ctrl access encodings
//             addr, wdata                 - byte address and store data
//             rdata                       - extended load data, held between loads
//             stall, align_err            - combinational CPU handshake
//             bus_err                     - one-cycle pulse after a timeout
//             mem_req/we/be/addr/wdata    - registered memory request
//             mem_ack, mem_rdata          - memory completion and read word
//  Revision : 1.0 - initial release
// ============================================================================
module dm_access_unit #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  LAddr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        align_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value before a timeout fires; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       ltype;    // 0 lw, 1 lb, 2 lbu, 3 lh, 4 lhu
  logic [1:0]       lane;
  logic             is_load;

  logic        is_store;
  logic        acc;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [2:0]  ltype_n;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;
  logic        timeout_hit;

  assign is_store = (MemWrite != 2'b00);
  assign acc      = MemRead | is_store;
  // Reserved load codes fold onto lw so they get word alignment checking.
  assign ltype_n  = (LAddr > 3'd4) ? 3'd0 : LAddr;

  always_comb begin
    misaligned = 1'b0;
    be_n       = 4'b1111;
    wdata_n    = 32'h0;
    if (is_store) begin
      case (MemWrite)
        2'b01: begin
          misaligned = (addr[1:0] != 2'b00);
          wdata_n    = wdata;
        end
        2'b10: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        default: begin
          misaligned = addr[0];
          be_n       = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n    = {2{wdata[15:0]}};
        end
      endcase
    end else begin
      case (ltype_n)
        3'd1, 3'd2: misaligned = 1'b0;
        3'd3, 3'd4: misaligned = addr[0];
        default:    misaligned = (addr[1:0] != 2'b00);
      endcase
    end
  end

  assign start     = (state == S_IDLE) && acc && !misaligned;
  assign stall     = start || (state == S_WAIT);
  assign align_err = (state == S_IDLE) && acc && misaligned;

  // Lane selection uses the address latched at request time, not the live bus.
  always_comb begin
    byte_v = mem_rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ltype)
      3'd1:    ext = {{24{byte_v[7]}}, byte_v};
      3'd2:    ext = {24'h0, byte_v};
      3'd3:    ext = {{16{half_v[15]}}, half_v};
      3'd4:    ext = {16'h0, half_v};
      default: ext = mem_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ltype     <= 3'd0;
      lane      <= 2'b00;
      is_load   <= 1'b0;
      rdata     <= 32'h0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'b0000;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (acc) begin
            if (misaligned) begin
              rdata <= 32'h0;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_be    <= be_n;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= wdata_n;
              ltype     <= ltype_n;
              lane      <= addr[1:0];
              is_load   <= !is_store;
              cnt       <= '0;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_load) rdata <= ext;
            state <= S_DONE;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            rdata   <= 32'h0;
            bus_err <= 1'b1;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          bus_err <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_access_unit
//  Purpose  : Directed bench for dm_access_unit. Stimulus pushes expected
//             requests and completions into queues; a monitor on the falling
//             edge pops and compares when the request rises or completes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead;
  logic [1:0]  MemWrite;
  logic [2:0]  LAddr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        align_err;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  dm_access_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .LAddr(LAddr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .align_err(align_err),
    .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        berr;
  } resp_t;

  req_t  req_q[$];
  resp_t resp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [31:0] exp_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic prev_req  = 1'b0;
  logic prev_done = 1'b0;
  req_t cur;

  always @(negedge clk) begin
    resp_t r;
    if (prev_done) chk("bus_err_pulse_end", {31'h0, bus_err}, 32'h0);
    prev_done = 1'b0;
    if (!rst && mem_req) begin
      if (!prev_req) begin
        if (req_q.size() == 0) begin
          chk("unexpected_req", 32'h1, 32'h0);
          cur = '0;
        end else begin
          cur = req_q.pop_front();
        end
      end
      chk("mem_we",   {31'h0, mem_we}, {31'h0, cur.we});
      chk("mem_be",   {28'h0, mem_be}, {28'h0, cur.be});
      chk("mem_addr", mem_addr, cur.addr);
      if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
    end
    if (!rst && prev_req && !mem_req) begin
      if (resp_q.size() == 0) begin
        chk("unexpected_done", 32'h1, 32'h0);
      end else begin
        r = resp_q.pop_front();
        chk("rdata",   rdata, r.rdata);
        chk("bus_err", {31'h0, bus_err}, {31'h0, r.berr});
        prev_done = 1'b1;
      end
    end
    prev_req = mem_req;
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    MemRead = 1'b0; MemWrite = 2'b00; LAddr = 3'b000; addr = 32'h0; wdata = 32'h0;
  endtask

  // Called at posedge+1 of the cycle the access is presented (cycle T).
  // ack_at = k means mem_ack is pulsed in cycle T+k; 0 means never.
  task automatic access(input logic mr, input logic [1:0] mw, input logic [2:0] la,
                        input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                        input logic [31:0] rd, input req_t exp_req, input resp_t exp_resp,
                        input int exp_stall, input string name);
    int n;
    bit done;
    MemRead = mr; MemWrite = mw; LAddr = la; addr = a; wdata = wd;
    req_q.push_back(exp_req);
    resp_q.push_back(exp_resp);
    n = 0;
    done = 1'b0;
    for (int idx = 0; idx < 40 && !done; idx++) begin
      #1;
      if (stall) n++;
      else done = 1'b1;
      if (!done) begin
        @(posedge clk); #1;
        mem_ack   = (ack_at != 0) && (idx + 1 == ack_at);
        mem_rdata = rd;
      end
    end
    if (!done) chk({name, "_stall_timeout"}, 32'h1, 32'h0);
    chk({name, "_stall_cycles"}, n, exp_stall);
    mem_ack = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic misaligned(input logic mr, input logic [1:0] mw, input logic [2:0] la,
                            input logic [31:0] a, input string name);
    MemRead = mr; MemWrite = mw; LAddr = la; addr = a; wdata = 32'hFFFF_FFFF;
    #1;
    chk({name, "_align_err"}, {31'h0, align_err}, 32'h1);
    chk({name, "_stall"}, {31'h0, stall}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk({name, "_no_req"}, {31'h0, mem_req}, 32'h0);
    end
    chk({name, "_rdata_zero"}, rdata, 32'h0);
    idle_inputs();
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] LD = 32'h80FF7F01;

  initial begin
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we}, 32'h0);
    chk("rst_mem_be",    {28'h0, mem_be}, 32'h0);
    chk("rst_mem_addr",  mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_rdata",     rdata, 32'h0);
    chk("rst_bus_err",   {31'h0, bus_err}, 32'h0);
    chk("rst_stall",     {31'h0, stall}, 32'h0);
    @(posedge clk); #1;

    // stores (rdata stays at its previous value)
    access(0, 2'b01, 3'b000, 32'h100, 32'hDEADBEEF, 2, 32'h0,
           '{1'b1, 4'b1111, 32'h100, 32'hDEADBEEF}, '{exp_rdata, 1'b0}, 3, "sw");
    access(1, 2'b10, 3'b000, 32'h103, 32'h000000A5, 1, 32'h0,
           '{1'b1, 4'b1000, 32'h100, 32'hA5A5A5A5}, '{exp_rdata, 1'b0}, 2, "sb");
    access(0, 2'b11, 3'b000, 32'h102, 32'h00001234, 3, 32'h0,
           '{1'b1, 4'b1100, 32'h100, 32'h12341234}, '{exp_rdata, 1'b0}, 4, "sh");
    access(0, 2'b11, 3'b000, 32'h100, 32'hCAFE5678, 1, 32'h0,
           '{1'b1, 4'b0011, 32'h100, 32'h56785678}, '{exp_rdata, 1'b0}, 2, "sh_lo");
    access(0, 2'b10, 3'b000, 32'h101, 32'h0000003C, 1, 32'h0,
           '{1'b1, 4'b0010, 32'h100, 32'h3C3C3C3C}, '{exp_rdata, 1'b0}, 2, "sb_l1");

    // loads with mem_rdata = 0x80FF7F01
    access(1, 2'b00, 3'b001, 32'h303, 32'h0, 1, LD,
           '{1'b0, 4'b1111, 32'h300, 32'h0}, '{32'hFFFFFF80, 1'b0}, 2, "lb3");
    access(1, 2'b00, 3'b010, 32'h303, 32'h0, 2, LD,
           '{1'b0, 4'b1111, 32'h300, 32'h0}, '{32'h00000080, 1'b0}, 3, "lbu3");
    access(1, 2'b00, 3'b011, 32'h302, 32'h0, 1, LD,
           '{1'b0, 4'b1111, 32'h300, 32'h0}, '{32'hFFFF80FF, 1'b0}, 2, "lh2");
    access(1, 2'b00, 3'b100, 32'h300, 32'h0, 1, LD,
           '{1'b0, 4'b1111, 32'h300, 32'h0}, '{32'h00007F01, 1'b0}, 2, "lhu0");
    access(1, 2'b00, 3'b001, 32'h301, 32'h0, 1, LD,
           '{1'b0, 4'b1111, 32'h300, 32'h0}, '{32'h0000007F, 1'b0}, 2, "lb1");
    access(1, 2'b00, 3'b000, 32'h304, 32'h0, 1, LD,
           '{1'b0, 4'b1111, 32'h304, 32'h0}, '{LD, 1'b0}, 2, "lw");

    // misaligned accesses
    misaligned(1, 2'b00, 3'b000, 32'h102, "lw_mis");
    misaligned(1, 2'b00, 3'b110, 32'h301, "lw_rsvd_mis");
    misaligned(0, 2'b11, 3'b000, 32'h101, "sh_mis");

    // timeout: TIMEOUT=4, no ack -> 4 WAIT cycles, bus_err, rdata=0
    access(1, 2'b00, 3'b000, 32'h200, 32'h0, 1, 32'h11223344,
           '{1'b0, 4'b1111, 32'h200, 32'h0}, '{32'h11223344, 1'b0}, 2, "lw_pre");
    access(1, 2'b00, 3'b000, 32'h200, 32'h0, 0, 32'h0,
           '{1'b0, 4'b1111, 32'h200, 32'h0}, '{32'h0, 1'b1}, 5, "lw_tmo");

    // reset mid-WAIT, then a late ack that must be dropped
    MemRead = 1'b1; LAddr = 3'b000; addr = 32'h400;
    req_q.push_back('{1'b0, 4'b1111, 32'h400, 32'h0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_req_high", {31'h0, mem_req}, 32'h1);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    chk("abort_req_drop", {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    chk("late_ack_stall", {31'h0, stall}, 32'h0);
    chk("late_ack_req",   {31'h0, mem_req}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_berr",  {31'h0, bus_err}, 32'h0);
    chk("req_q_empty",  req_q.size(), 32'h0);
    chk("resp_q_empty", resp_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
